// File: rtl/ftdl_row_dispatch_if.sv
// Signal bundle between the activation/parameter source, the row dispatcher and the superblock rows.
// The master side is the source plus the rows; the slave side is the dispatcher.
interface ftdl_row_dispatch_if #(
  parameter int NUM_ROWS = 4,
  parameter int DATA_W   = 32,
  parameter int PARAM_W  = 64
);
  logic [NUM_ROWS-1:0] row_en_mask;
  logic [DATA_W-1:0]   act_in_data;
  logic                act_in_vld;
  logic                act_in_rdy;
  logic [DATA_W-1:0]   row_act_data;
  logic [NUM_ROWS-1:0] row_act_vld;
  logic [NUM_ROWS-1:0] row_act_req;
  logic [PARAM_W-1:0]  param_in;
  logic [NUM_ROWS-1:0] param_row_sel;
  logic                param_in_vld;
  logic                param_in_rdy;
  logic [PARAM_W-1:0]  row_param;
  logic [NUM_ROWS-1:0] row_param_en;
  logic [NUM_ROWS-1:0] row_busy;
  logic                all_done;
  logic                done_pulse;
  logic [15:0]         act_word_cnt;

  modport master (
    output row_en_mask, act_in_data, act_in_vld, row_act_req,
           param_in, param_row_sel, param_in_vld, row_busy,
    input  act_in_rdy, row_act_data, row_act_vld, param_in_rdy,
           row_param, row_param_en, all_done, done_pulse, act_word_cnt
  );

  modport slave (
    input  row_en_mask, act_in_data, act_in_vld, row_act_req,
           param_in, param_row_sel, param_in_vld, row_busy,
    output act_in_rdy, row_act_data, row_act_vld, param_in_rdy,
           row_param, row_param_en, all_done, done_pulse, act_word_cnt
  );
endinterface

// File: rtl/ftdl_row_dispatch.sv
// Activation FIFO with lockstep broadcast to enabled rows, a serialised parameter-load FSM
// and aggregated row status (all_done level, done pulse, broadcast word counter).
module ftdl_row_dispatch #(
  parameter int NUM_ROWS   = 4,
  parameter int DATA_W     = 32,
  parameter int PARAM_W    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int PARAM_GAP  = 2
) (
  input  logic               clk_h,
  input  logic               rst,
  ftdl_row_dispatch_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       GAP_C   = 4'(PARAM_GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                act_in_rdy_q;
  state_e              state_q;
  logic [PARAM_W-1:0]  param_lat_q;
  logic [NUM_ROWS-1:0] sel_lat_q;
  logic [3:0]          gap_q;
  logic [DATA_W-1:0]   row_act_data_q;
  logic [NUM_ROWS-1:0] row_act_vld_q;
  logic [PARAM_W-1:0]  row_param_q;
  logic [NUM_ROWS-1:0] row_param_en_q;
  logic                all_done_q;
  logic                done_pulse_q;
  logic [15:0]         act_word_cnt_q;

  logic push_s, issue_s, reqs_ok_s, all_done_s, param_rdy_s, param_acc_s;

  // Rows that are disabled never hold back a broadcast.
  assign reqs_ok_s   = &(bus.row_act_req | ~bus.row_en_mask);
  assign push_s      = bus.act_in_vld & act_in_rdy_q;
  assign issue_s     = (count_q != {CNT_W{1'b0}}) & (state_q == ST_IDLE)
                     & (|bus.row_en_mask) & reqs_ok_s;
  assign all_done_s  = (|bus.row_en_mask) & (&(~bus.row_busy | ~bus.row_en_mask));
  assign param_rdy_s = (state_q == ST_IDLE) & (count_q == {CNT_W{1'b0}}) & all_done_q;
  assign param_acc_s = bus.param_in_vld & param_rdy_s;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_h) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.act_in_data;
    end
  end

  // FIFO pointers, broadcast path, parameter FSM and status registers.
  always_ff @(posedge clk_h) begin
    if (rst) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      act_in_rdy_q   <= 1'b0;
      state_q        <= ST_IDLE;
      param_lat_q    <= {PARAM_W{1'b0}};
      sel_lat_q      <= {NUM_ROWS{1'b0}};
      gap_q          <= 4'd0;
      row_act_data_q <= {DATA_W{1'b0}};
      row_act_vld_q  <= {NUM_ROWS{1'b0}};
      row_param_q    <= {PARAM_W{1'b0}};
      row_param_en_q <= {NUM_ROWS{1'b0}};
      all_done_q     <= 1'b0;
      done_pulse_q   <= 1'b0;
      act_word_cnt_q <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (issue_s) begin
        rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
        row_act_data_q <= mem_q[rd_ptr_q];
      end
      count_q        <= count_d;
      act_in_rdy_q   <= (count_d != DEPTH_C);
      row_act_vld_q  <= issue_s ? bus.row_en_mask : {NUM_ROWS{1'b0}};
      all_done_q     <= all_done_s;
      done_pulse_q   <= all_done_s & ~all_done_q;
      row_param_en_q <= {NUM_ROWS{1'b0}};

      // No broadcast can coincide with ISSUE, so the clear never races an increment.
      if (state_q == ST_ISSUE) begin
        act_word_cnt_q <= 16'd0;
      end else if (issue_s && (act_word_cnt_q != 16'hFFFF)) begin
        act_word_cnt_q <= act_word_cnt_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (param_acc_s) begin
            param_lat_q <= bus.param_in;
            sel_lat_q   <= bus.param_row_sel;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          row_param_q    <= param_lat_q;
          row_param_en_q <= sel_lat_q & bus.row_en_mask;
          gap_q          <= GAP_C;
          state_q        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
          end
          if (gap_q <= 4'd1) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.act_in_rdy   = act_in_rdy_q;
  assign bus.row_act_data = row_act_data_q;
  assign bus.row_act_vld  = row_act_vld_q;
  assign bus.param_in_rdy = param_rdy_s;
  assign bus.row_param    = row_param_q;
  assign bus.row_param_en = row_param_en_q;
  assign bus.all_done     = all_done_q;
  assign bus.done_pulse   = done_pulse_q;
  assign bus.act_word_cnt = act_word_cnt_q;
endmodule

// File: tb/tb_ftdl_row_dispatch.sv
// Directed plus randomized bench for ftdl_row_dispatch against a transaction-level model
// (word queue, parameter blocking window, saturating broadcast count).
module tb_ftdl_row_dispatch;
  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int PW    = 64;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ftdl_row_dispatch_if #(.NUM_ROWS(NR), .DATA_W(DW), .PARAM_W(PW)) bus ();

  ftdl_row_dispatch #(
    .NUM_ROWS(NR), .DATA_W(DW), .PARAM_W(PW), .FIFO_DEPTH(DEPTH), .PARAM_GAP(GAP)
  ) dut (
    .clk_h(clk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the dispatcher should present after the latest edge.
  logic [DW-1:0] m_fifo[$];
  int            m_blk    = 0;
  logic [PW-1:0] m_plat   = '0;
  logic [PW-1:0] m_pout   = '0;
  logic [NR-1:0] m_sel    = '0;
  logic [NR-1:0] m_pen    = '0;
  logic [NR-1:0] m_vld    = '0;
  logic [DW-1:0] m_data   = '0;
  logic [15:0]   m_cnt    = '0;
  logic          m_done   = 1'b0;
  logic          m_pulse  = 1'b0;
  logic          m_rdy    = 1'b0;
  logic          m_pushed = 1'b0;
  logic          m_acc    = 1'b0;

  // Observation counters for directed checks.
  int            n_strobe  = 0;
  int            n_pstrobe = 0;
  int            n_pulse   = 0;
  int            n_hs      = 0;
  logic [NR-1:0] last_vld  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic          issue;
    logic          prdy;
    logic          done_n;
    logic [NR-1:0] mask;
    @(posedge clk);
    mask     = bus.row_en_mask;
    if (bus.act_in_vld && bus.act_in_rdy) n_hs++;
    m_pushed = 1'b0;
    m_acc    = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_blk   = 0;
      m_plat  = '0;
      m_pout  = '0;
      m_sel   = '0;
      m_pen   = '0;
      m_vld   = '0;
      m_data  = '0;
      m_cnt   = '0;
      m_done  = 1'b0;
      m_pulse = 1'b0;
      m_rdy   = 1'b0;
    end else begin
      m_pushed = bus.act_in_vld && m_rdy;
      prdy     = (m_blk == 0) && (m_fifo.size() == 0) && m_done;
      m_acc    = bus.param_in_vld && prdy;
      issue    = (m_fifo.size() > 0) && (m_blk == 0) && (mask != '0)
               && ((bus.row_act_req | ~mask) == {NR{1'b1}});
      m_vld = '0;
      if (issue) begin
        m_data = m_fifo.pop_front();
        m_vld  = mask;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (m_pushed) m_fifo.push_back(bus.act_in_data);
      m_pen = '0;
      if (m_blk == GAP + 1) begin
        m_pout = m_plat;
        m_pen  = m_sel & mask;
        m_cnt  = '0;
      end
      if (m_acc) begin
        m_plat = bus.param_in;
        m_sel  = bus.param_row_sel;
        m_blk  = GAP + 1;
      end else if (m_blk > 0) begin
        m_blk--;
      end
      done_n  = (mask != '0) && ((bus.row_busy & mask) == '0);
      m_pulse = done_n && !m_done;
      m_done  = done_n;
      m_rdy   = (m_fifo.size() < DEPTH);
    end
    #1;
    if (bus.row_act_vld != '0) begin
      n_strobe++;
      last_vld = bus.row_act_vld;
    end
    if (bus.row_param_en != '0) n_pstrobe++;
    if (bus.done_pulse) n_pulse++;
    chk("act_in_rdy",   bus.act_in_rdy,   m_rdy);
    chk("row_act_vld",  bus.row_act_vld,  m_vld);
    chk("row_act_data", bus.row_act_data, m_data);
    chk("param_in_rdy", bus.param_in_rdy,
        (m_blk == 0) && (m_fifo.size() == 0) && m_done);
    chk("row_param",    bus.row_param,    m_pout);
    chk("row_param_en", bus.row_param_en, m_pen);
    chk("all_done",     bus.all_done,     m_done);
    chk("done_pulse",   bus.done_pulse,   m_pulse);
    chk("act_word_cnt", bus.act_word_cnt, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int   idx;
    logic found;

    bus.row_en_mask   = '0;
    bus.act_in_data   = '0;
    bus.act_in_vld    = 1'b0;
    bus.row_act_req   = '0;
    bus.param_in      = '0;
    bus.param_row_sel = '0;
    bus.param_in_vld  = 1'b0;
    bus.row_busy      = '0;

    // Reset: all outputs low, ready rises the cycle after release.
    rst = 1'b1;
    run(2);
    chk("rst_rdy", bus.act_in_rdy, 1'b0);
    chk("rst_cnt", bus.act_word_cnt, 16'd0);
    rst = 1'b0;
    tick();
    chk("rdy_rise", bus.act_in_rdy, 1'b1);

    // Fill with no requests: four words accepted, the fifth held upstream.
    bus.row_en_mask = 4'b1111;
    bus.row_act_req = 4'b0000;
    idx      = 0;
    n_hs     = 0;
    n_strobe = 0;
    for (int k = 0; k < 8; k++) begin
      bus.act_in_vld  = 1'b1;
      bus.act_in_data = 32'h11 + 32'(idx);
      tick();
      if (m_pushed) idx++;
    end
    chk("fill_rdy_low", bus.act_in_rdy, 1'b0);
    chk("fill_accepted", 64'(n_hs), 64'd4);
    chk("fill_no_strobe", 64'(n_strobe), 64'd0);

    // Lockstep broadcast of all five words.
    bus.row_act_req = 4'b1111;
    n_strobe = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_pushed) bus.act_in_vld = 1'b0;
    end
    chk("bcast_strobes", 64'(n_strobe), 64'd5);
    chk("bcast_word_cnt", bus.act_word_cnt, 16'd5);

    // Masked rows and a three-cycle stall on an enabled row.
    bus.row_en_mask = 4'b0101;
    bus.row_act_req = 4'b0111;
    bus.act_in_vld  = 1'b1;
    bus.act_in_data = 32'h20;
    tick();
    bus.row_act_req = 4'b0011;
    n_strobe = 0;
    bus.act_in_data = 32'h21;
    tick();
    bus.act_in_data = 32'h22;
    tick();
    bus.act_in_vld = 1'b0;
    tick();
    chk("stall_no_strobe", 64'(n_strobe), 64'd0);
    bus.row_act_req = 4'b0111;
    run(6);
    chk("stall_resume", 64'(n_strobe), 64'd3);
    chk("mask_vld", last_vld, 4'b0101);

    // Parameter load gated by a pending word and a busy row.
    bus.row_en_mask = 4'b1111;
    bus.row_act_req = 4'b0000;
    bus.row_busy    = 4'b0010;
    bus.act_in_vld  = 1'b1;
    bus.act_in_data = 32'h31;
    tick();
    bus.act_in_vld    = 1'b0;
    bus.param_in      = 64'hA5;
    bus.param_row_sel = 4'b1111;
    bus.param_in_vld  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prdy_fifo_block", bus.param_in_rdy, 1'b0);
    end
    bus.row_act_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prdy_busy_block", bus.param_in_rdy, 1'b0);
    end
    bus.row_busy = 4'b0000;
    n_pstrobe = 0;
    found     = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (m_acc) begin
        bus.param_in_vld = 1'b0;
        bus.act_in_vld   = 1'b1;
        bus.act_in_data  = 32'h32;
      end else if (m_pushed) begin
        bus.act_in_vld = 1'b0;
      end
      if (bus.row_param_en != '0) found = 1'b1;
    end
    chk("pen_seen", found, 1'b1);
    chk("pen_value", bus.row_param_en, 4'b1111);
    chk("pen_param", bus.row_param, 64'hA5);
    chk("pen_cnt_clear", bus.act_word_cnt, 16'd0);
    bus.act_in_vld = 1'b0;
    for (int k = 0; k < GAP; k++) begin
      tick();
      chk("gap_no_vld", bus.row_act_vld, 4'b0000);
    end
    run(4);
    chk("pen_once", 64'(n_pstrobe), 64'd1);

    // Done pulse on the busy -> idle transition, and only once.
    bus.row_busy = 4'b1000;
    run(3);
    chk("done_low", bus.all_done, 1'b0);
    bus.row_busy = 4'b0000;
    tick();
    chk("done_rise", bus.all_done, 1'b1);
    chk("pulse_on", bus.done_pulse, 1'b1);
    n_pulse = 0;
    run(4);
    chk("pulse_single", 64'(n_pulse), 64'd0);
    chk("done_hold", bus.all_done, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus.row_en_mask   = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
      bus.row_act_req   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      bus.row_busy      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.act_in_vld    = 1'($urandom);
      bus.act_in_data   = $urandom;
      bus.param_in_vld  = ($urandom_range(0, 7) == 0);
      bus.param_in      = {$urandom, $urandom};
      bus.param_row_sel = 4'($urandom);
      tick();
    end

    // Drain, then reset while three words are buffered and the FSM is waiting.
    bus.row_en_mask  = 4'b1111;
    bus.row_act_req  = 4'b1111;
    bus.row_busy     = 4'b0000;
    bus.act_in_vld   = 1'b0;
    bus.param_in_vld = 1'b0;
    run(12);
    bus.row_act_req   = 4'b0000;
    bus.param_in      = 64'hBEEF;
    bus.param_row_sel = 4'b0011;
    bus.param_in_vld  = 1'b1;
    bus.act_in_vld    = 1'b1;
    bus.act_in_data   = 32'h41;
    tick();
    bus.param_in_vld = 1'b0;
    bus.act_in_data  = 32'h42;
    tick();
    bus.act_in_data  = 32'h43;
    tick();
    bus.act_in_vld = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", bus.act_in_rdy, 1'b0);
    chk("mid_rst_pen", bus.row_param_en, 4'b0000);
    chk("mid_rst_param", bus.row_param, 64'd0);
    rst = 1'b0;
    bus.row_act_req = 4'b1111;
    bus.act_in_vld  = 1'b1;
    bus.act_in_data = 32'h51;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (m_pushed) bus.act_in_vld = 1'b0;
      if (bus.row_act_vld != '0) begin
        found = 1'b1;
        chk("post_rst_first", bus.row_act_data, 32'h51);
      end
    end
    chk("post_rst_seen", found, 1'b1);
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ftdl_row_dispatch.md
Name: ftdl_row_dispatch

Overview:
- Parametrised dispatcher between the activation/parameter source and NUM_ROWS superblock rows.
- Buffers incoming activation words in a FIFO and broadcasts each word in lockstep to all enabled rows, only when every enabled row requests data.
- Serialises layer-parameter loads through an FSM. A parameter load is applied only when no activation word is pending and every enabled row is idle.
- Aggregates row status into a level signal and a done pulse, and keeps a broadcast word counter.

Parameters:
- NUM_ROWS, 4: number of superblock rows driven (1..16).
- DATA_W, 32: activation word width.
- PARAM_W, 64: parameter word width.
- FIFO_DEPTH, 4: activation FIFO depth. Power of two, 2..64.
- PARAM_GAP, 2: settle cycles after a parameter strobe before the dispatcher returns to IDLE (1..15).

Ports:
- clk_h  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- row_en_mask  in  NUM_ROWS  1 = row participates. Sampled every cycle.
- act_in_data  in  DATA_W  upstream activation word.
- act_in_vld  in  1  upstream word valid.
- act_in_rdy  out  1  FIFO not full. A word transfers when vld & rdy.
- row_act_data  out  DATA_W  broadcast word, registered.
- row_act_vld  out  NUM_ROWS  per-row one-cycle write strobe, registered.
- row_act_req  in  NUM_ROWS  row can absorb 2 more words.
- param_in  in  PARAM_W  parameter word.
- param_row_sel  in  NUM_ROWS  target rows for param_in.
- param_in_vld  in  1  parameter valid.
- param_in_rdy  out  1  parameter accept.
- row_param  out  PARAM_W  registered parameter word.
- row_param_en  out  NUM_ROWS  one-cycle load strobe per row.
- row_busy  in  NUM_ROWS  row is computing.
- all_done  out  1  every enabled row is idle, registered.
- done_pulse  out  1  one cycle on the 0->1 edge of all_done.
- act_word_cnt  out  16  words broadcast since the last parameter strobe.

Behaviour:
- Reset (rst=1 at a clock edge): FIFO emptied, FSM to IDLE. All outputs are 0, including act_in_rdy, param_in_rdy, all_done and act_word_cnt. act_in_rdy rises the cycle after rst deasserts. Reset mid-operation discards buffered words and any latched parameter.
- FIFO: push on act_in_vld & act_in_rdy. act_in_rdy = !full, registered-count based.
  - Push on full is impossible.
  - Simultaneous push and pop at full or at empty keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue condition (evaluated at cycle t): all of the following hold.
  - FIFO non-empty.
  - FSM == IDLE.
  - row_en_mask != 0.
  - (row_act_req | ~row_en_mask) is all ones.
- Issue action:
  - Pop the head.
  - At t+1: row_act_data = head and row_act_vld = row_en_mask as sampled at t. row_act_vld is 0 in every other cycle.
  - act_word_cnt += 1, saturating at 0xFFFF.
  - Issues may occur back-to-back.
- Latency: a word accepted at cycle N is broadcast at N+2 at the earliest.
- mask == 0: no issue. The FIFO holds its contents and fills until full.
- Parameter FSM:
  - IDLE: param_in_rdy = FIFO empty & all_done. On accept (vld & rdy), latch param_in and param_row_sel, go to ISSUE. Issue is blocked in the same cycle because the FIFO is empty.
  - ISSUE (1 cycle): row_param = latched word. row_param_en = latched sel & row_en_mask, asserted for exactly this cycle. act_word_cnt cleared. Load PARAM_GAP into the gap counter. Go to WAIT.
  - WAIT: decrement the gap counter. Go to IDLE in the cycle after the counter reaches 1, i.e. PARAM_GAP cycles in WAIT. Upstream FIFO fill continues, but no issue.
  - param_in_rdy = 0 outside IDLE.
  - A sel that is 0 after masking still passes through ISSUE and WAIT, with row_param_en all 0.
- row_param holds its value until the next ISSUE.
- Status:
  - all_done(t+1) = &(~row_busy | ~row_en_mask) at t.
  - all_done = 0 when mask == 0.
  - done_pulse = all_done & !all_done_prev.
  - No done_pulse in the first cycle after reset.

Test Plan:
- Reset and fill: NUM_ROWS=4, mask=4'b1111, row_act_req=0, push 5 words 0x11..0x15. Required: act_in_rdy drops after 4 words, row_act_vld stays 0, and the 5th word is held upstream.
- Lockstep broadcast: continuing from above, raise row_act_req=4'b1111. Required:
  - row_act_vld=4'b1111 on 4 consecutive cycles with data 0x11..0x14 in order.
  - 0x15 is accepted and broadcast last.
  - act_word_cnt=5.
- Masking and stall: mask=4'b0101, row_act_req=4'b0111, then req[2]=0 for 3 cycles. Required: row_act_vld=4'b0101 while req holds, no strobe during the 3-cycle stall, and order is preserved.
- Parameter gating: FIFO holds 1 word, row_busy=4'b0010, param_in=64'hA5, sel=4'b1111. Required:
  - param_in_rdy stays 0 until the FIFO drains and row_busy=0.
  - row_param_en=4'b1111 for exactly 1 cycle.
  - act_word_cnt cleared.
  - No row_act_vld for PARAM_GAP=2 cycles after the strobe.
- Done pulse: mask=4'b1111, row_busy goes from 4'b1000 to 4'b0000. Required: all_done rises one cycle later, done_pulse lasts exactly 1 cycle, and no pulse occurs while all_done stays high.
- Mid-operation reset: FIFO holds 3 words and the FSM is in WAIT; assert rst for 1 cycle. Required: all outputs 0 and FIFO empty, and after reset a new word is the first one broadcast.
